// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared state encoding and default timing for the step/dir ramp driver
//
// Purpose: state enumeration shared by the step/dir driver and its helpers,
//          plus the default driver timing expressed in 50 MHz cycles.
// Ports:   none (package).

package stepper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_PAUSE = 3'd4
   } state_e;

   localparam int PULSE_HI_50M  = 50;
   localparam int DIR_SETUP_50M = 10;

endpackage

// File: rtl/stepper_ramp_driver_if.sv
// rtl/stepper_ramp_driver_if.sv - move-command handshake between sequencer and step/dir driver
//
// Purpose: groups the move command fields and their valid/ready handshake.
// Ports (signals):
//   cmd_valid      master->slave  command present
//   cmd_ready      slave->master  driver can accept a command
//   cmd_steps      master->slave  steps to issue
//   cmd_dir        master->slave  direction, 1 = positive
//   cmd_per_start  master->slave  first/last step period in cycles
//   cmd_per_min    master->slave  cruise period in cycles
//   cmd_accel      master->slave  period change per step while ramping

interface stepper_ramp_driver_if #(
   parameter int STEP_W = 16,
   parameter int PER_W  = 24
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [STEP_W-1:0] cmd_steps;
   logic              cmd_dir;
   logic [PER_W-1:0]  cmd_per_start;
   logic [PER_W-1:0]  cmd_per_min;
   logic [PER_W-1:0]  cmd_accel;

   modport master (
      output cmd_valid, cmd_steps, cmd_dir, cmd_per_start, cmd_per_min, cmd_accel,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_dir, cmd_per_start, cmd_per_min, cmd_accel,
      output cmd_ready
   );

endinterface

// File: rtl/step_ramp_calc.sv
// rtl/step_ramp_calc.sv - next step period and ramp counter for a trapezoidal profile
//
// Purpose: combinational period update evaluated at each step boundary.
// Ports:
//   cur_per        in   period of the step just finished
//   per_min        in   clamped cruise period
//   per_start      in   clamped start/end period
//   accel          in   period change per ramp step
//   remaining      in   steps still to issue
//   ramp_cnt       in   steps spent accelerating so far (net)
//   next_per       out  period for the next step
//   next_ramp_cnt  out  updated ramp counter

import stepper_pkg::*;

module step_ramp_calc #(
   parameter int STEP_W = 16,
   parameter int PER_W  = 24
) (
   input  logic [PER_W-1:0]  cur_per,
   input  logic [PER_W-1:0]  per_min,
   input  logic [PER_W-1:0]  per_start,
   input  logic [PER_W-1:0]  accel,
   input  logic [STEP_W-1:0] remaining,
   input  logic [STEP_W-1:0] ramp_cnt,
   output logic [PER_W-1:0]  next_per,
   output logic [STEP_W-1:0] next_ramp_cnt
);

   // One extra bit so sums saturate and differences detect borrow instead of wrapping.
   logic [PER_W:0] sum;
   logic [PER_W:0] diff;

   always_comb begin
      sum           = {1'b0, cur_per} + {1'b0, accel};
      diff          = {1'b0, cur_per} - {1'b0, accel};
      next_per      = cur_per;
      next_ramp_cnt = ramp_cnt;
      if (remaining <= ramp_cnt) begin
         // Decelerate: as many steps remain as were spent accelerating.
         next_per = (sum > {1'b0, per_start}) ? per_start : sum[PER_W-1:0];
         if (ramp_cnt != '0) begin
            next_ramp_cnt = ramp_cnt - STEP_W'(1);
         end
      end else if (cur_per > per_min) begin
         next_per = (diff[PER_W] || (diff[PER_W-1:0] < per_min)) ? per_min : diff[PER_W-1:0];
         next_ramp_cnt = ramp_cnt + STEP_W'(1);
      end
   end

endmodule

// File: rtl/stepper_ramp_driver.sv
// rtl/stepper_ramp_driver.sv - step/dir pulse generator with trapezoidal accel/decel
//
// Purpose: accepts move commands and drives STEP/DIR pins with min high/low
//          and dir-setup timing, tracking signed absolute position.
// Ports:
//   clk_50      in   50 MHz system clock
//   reset_n     in   asynchronous active-low reset
//   cmd         slave modport of stepper_ramp_driver_if (move command handshake)
//   enable      in   0 = pause at next step boundary
//   abort       in   level; stop at next step boundary
//   step        out  STEP pin
//   dir         out  DIR pin
//   busy        out  high whenever not idle
//   done        out  one-cycle pulse at end of move
//   aborted     out  sticky, valid with done, cleared on next accept
//   steps_done  out  rising edges issued in current/last move
//   position    out  signed absolute position

import stepper_pkg::*;

module stepper_ramp_driver #(
   parameter int STEP_W    = 16,
   parameter int PER_W     = 24,
   parameter int POS_W     = 32,
   parameter int PULSE_HI  = PULSE_HI_50M,
   parameter int DIR_SETUP = DIR_SETUP_50M
) (
   input  logic                    clk_50,
   input  logic                    reset_n,
   stepper_ramp_driver_if.slave    cmd,
   input  logic                    enable,
   input  logic                    abort,
   output logic                    step,
   output logic                    dir,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [STEP_W-1:0]       steps_done,
   output logic signed [POS_W-1:0] position
);

   localparam logic [2:0] IDLE  = ST_IDLE;
   localparam logic [2:0] SETUP = ST_SETUP;
   localparam logic [2:0] HIGH  = ST_HIGH;
   localparam logic [2:0] LOW   = ST_LOW;
   localparam logic [2:0] PAUSE = ST_PAUSE;

   // Shortest legal period: one full high time plus an equal low time.
   localparam logic [PER_W-1:0] MIN_PER    = PER_W'(2 * PULSE_HI);
   localparam logic [PER_W-1:0] HI_LOAD    = PER_W'(PULSE_HI - 1);
   localparam logic [PER_W-1:0] SETUP_LOAD = PER_W'((DIR_SETUP > 0) ? DIR_SETUP - 1 : 0);
   localparam logic [PER_W-1:0] LOW_OFS    = PER_W'(PULSE_HI + 1);

   logic [2:0]        state;
   logic [PER_W-1:0]  tmr;
   logic [PER_W-1:0]  cur_per;
   logic [PER_W-1:0]  per_min_q;
   logic [PER_W-1:0]  per_start_q;
   logic [PER_W-1:0]  accel_q;
   logic [STEP_W-1:0] steps_q;
   logic [STEP_W-1:0] ramp_cnt;

   logic [PER_W-1:0]  clamp_min;
   logic [PER_W-1:0]  clamp_start;
   logic [STEP_W-1:0] remaining;
   logic [PER_W-1:0]  next_per;
   logic [STEP_W-1:0] next_ramp_cnt;
   logic [PER_W-1:0]  low_load;

   function automatic logic signed [POS_W-1:0] pos_step(input logic signed [POS_W-1:0] p,
                                                         input logic d);
      return d ? (p + POS_W'(1)) : (p - POS_W'(1));
   endfunction

   always_comb begin
      clamp_min   = (cmd.cmd_per_min > MIN_PER) ? cmd.cmd_per_min : MIN_PER;
      clamp_start = (cmd.cmd_per_start > clamp_min) ? cmd.cmd_per_start : clamp_min;
   end

   assign remaining     = steps_q - steps_done;
   // cur_per >= 2*PULSE_HI, so the low count never underflows.
   assign low_load      = cur_per - LOW_OFS;
   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);

   step_ramp_calc #(
      .STEP_W (STEP_W),
      .PER_W  (PER_W)
   ) u_calc (
      .cur_per       (cur_per),
      .per_min       (per_min_q),
      .per_start     (per_start_q),
      .accel         (accel_q),
      .remaining     (remaining),
      .ramp_cnt      (ramp_cnt),
      .next_per      (next_per),
      .next_ramp_cnt (next_ramp_cnt)
   );

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tmr         <= '0;
         cur_per     <= '0;
         per_min_q   <= '0;
         per_start_q <= '0;
         accel_q     <= '0;
         steps_q     <= '0;
         ramp_cnt    <= '0;
         step        <= 1'b0;
         dir         <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         steps_done  <= '0;
         position    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  steps_q     <= cmd.cmd_steps;
                  per_min_q   <= clamp_min;
                  per_start_q <= clamp_start;
                  accel_q     <= cmd.cmd_accel;
                  cur_per     <= clamp_start;
                  ramp_cnt    <= '0;
                  steps_done  <= '0;
                  aborted     <= 1'b0;
                  if (cmd.cmd_steps == '0) begin
                     done <= 1'b1;
                  end else if ((cmd.cmd_dir != dir) && (DIR_SETUP > 0)) begin
                     dir   <= cmd.cmd_dir;
                     state <= SETUP;
                     tmr   <= SETUP_LOAD;
                  end else begin
                     // No setup needed: first rising edge on this same clock.
                     dir        <= cmd.cmd_dir;
                     state      <= HIGH;
                     step       <= 1'b1;
                     tmr        <= HI_LOAD;
                     steps_done <= STEP_W'(1);
                     position   <= pos_step(position, cmd.cmd_dir);
                  end
               end
            end
            SETUP: begin
               if (tmr == '0) begin
                  state      <= HIGH;
                  step       <= 1'b1;
                  tmr        <= HI_LOAD;
                  steps_done <= steps_done + STEP_W'(1);
                  position   <= pos_step(position, dir);
               end else begin
                  tmr <= tmr - PER_W'(1);
               end
            end
            HIGH: begin
               if (tmr == '0) begin
                  state <= LOW;
                  step  <= 1'b0;
                  tmr   <= low_load;
               end else begin
                  tmr <= tmr - PER_W'(1);
               end
            end
            LOW: begin
               if (tmr == '0) begin
                  cur_per  <= next_per;
                  ramp_cnt <= next_ramp_cnt;
                  if (remaining == '0) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else if (abort) begin
                     state   <= IDLE;
                     done    <= 1'b1;
                     aborted <= 1'b1;
                  end else if (!enable) begin
                     state <= PAUSE;
                  end else begin
                     state      <= HIGH;
                     step       <= 1'b1;
                     tmr        <= HI_LOAD;
                     steps_done <= steps_done + STEP_W'(1);
                     position   <= pos_step(position, dir);
                  end
               end else begin
                  tmr <= tmr - PER_W'(1);
               end
            end
            PAUSE: begin
               // The low time before pausing already met the minimum, so resume
               // goes straight to a rising edge.
               if (abort) begin
                  state   <= IDLE;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (enable) begin
                  state      <= HIGH;
                  step       <= 1'b1;
                  tmr        <= HI_LOAD;
                  steps_done <= steps_done + STEP_W'(1);
                  position   <= pos_step(position, dir);
               end
            end
            default: begin
               state <= IDLE;
               step  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stepper_ramp_driver.sv
// tb/tb_stepper_ramp_driver.sv - directed self-checking bench for stepper_ramp_driver

module tb_stepper_ramp_driver;

   logic               clk_50 = 1'b0;
   logic               reset_n;
   logic               enable;
   logic               abort;
   logic               step;
   logic               dir;
   logic               busy;
   logic               done;
   logic               aborted;
   logic [15:0]        steps_done;
   logic signed [31:0] position;

   stepper_ramp_driver_if #(.STEP_W(16), .PER_W(24)) cmd_if ();

   stepper_ramp_driver dut (
      .clk_50     (clk_50),
      .reset_n    (reset_n),
      .cmd        (cmd_if),
      .enable     (enable),
      .abort      (abort),
      .step       (step),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .steps_done (steps_done),
      .position   (position)
   );

   always #10 clk_50 = ~clk_50;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_rise = 0;
   int n_fall = 0;
   int rise_t [0:511];
   int fall_t [0:511];
   int dir_fall_t = 0;
   int acc_cyc = 0;
   int done_t = 0;
   int base = 0;
   logic step_q = 1'b0;
   logic dir_q  = 1'b0;
   int exp_p [0:9];

   always @(posedge clk_50) cyc <= cyc + 1;

   always @(negedge clk_50) begin
      if (step && !step_q && n_rise < 512) begin
         rise_t[n_rise] = cyc;
         n_rise++;
      end
      if (!step && step_q && n_fall < 512) begin
         fall_t[n_fall] = cyc;
         n_fall++;
      end
      if (!dir && dir_q) dir_fall_t = cyc;
      step_q = step;
      dir_q  = dir;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int steps, input bit d, input int ps, input int pm, input int acc);
      @(negedge clk_50);
      chk("ready_before_send", longint'(cmd_if.cmd_ready), 1);
      cmd_if.cmd_steps     = 16'(steps);
      cmd_if.cmd_dir       = d;
      cmd_if.cmd_per_start = 24'(ps);
      cmd_if.cmd_per_min   = 24'(pm);
      cmd_if.cmd_accel     = 24'(acc);
      cmd_if.cmd_valid     = 1'b1;
      @(negedge clk_50);
      cmd_if.cmd_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk_50);
         n++;
      end
      chk({tag, "_done_seen"}, longint'(done), 1);
      done_t = cyc;
   endtask

   initial begin
      reset_n = 1'b0;
      enable  = 1'b1;
      abort   = 1'b0;
      cmd_if.cmd_valid     = 1'b0;
      cmd_if.cmd_steps     = '0;
      cmd_if.cmd_dir       = 1'b0;
      cmd_if.cmd_per_start = '0;
      cmd_if.cmd_per_min   = '0;
      cmd_if.cmd_accel     = '0;
      exp_p = '{1000, 800, 600, 400, 400, 400, 400, 600, 800, 1000};

      // Reset state
      repeat (3) @(negedge clk_50);
      chk("rst_step", longint'(step), 0);
      chk("rst_dir", longint'(dir), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_aborted", longint'(aborted), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_steps_done", longint'(steps_done), 0);
      chk("rst_position", longint'(position), 0);
      chk("rst_ready", longint'(cmd_if.cmd_ready), 1);
      reset_n = 1'b1;
      @(negedge clk_50);

      // Constant-speed move, direction change 0 -> 1
      base = n_rise;
      send(4, 1'b1, 200, 200, 0);
      wait_done("t1", 2000);
      chk("t1_pulses", longint'(n_rise - base), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t1_hi%0d", k), longint'(fall_t[base+k] - rise_t[base+k]), 50);
      for (int k = 0; k < 3; k++)
         chk($sformatf("t1_per%0d", k), longint'(rise_t[base+k+1] - rise_t[base+k]), 200);
      chk("t1_last_per", longint'(done_t - rise_t[base+3]), 200);
      chk("t1_position", longint'(position), 4);
      chk("t1_steps_done", longint'(steps_done), 4);
      chk("t1_aborted", longint'(aborted), 0);
      chk("t1_busy", longint'(busy), 0);
      @(negedge clk_50);
      chk("t1_done_one_cycle", longint'(done), 0);

      // Direction change 1 -> 0, setup time to first rising edge
      base = n_rise;
      send(1, 1'b0, 200, 200, 0);
      wait_done("t2", 1000);
      chk("t2_pulses", longint'(n_rise - base), 1);
      chk("t2_dir_setup", longint'(rise_t[base] - dir_fall_t), 10);
      chk("t2_dir", longint'(dir), 0);
      chk("t2_position", longint'(position), 3);
      chk("t2_steps_done", longint'(steps_done), 1);

      // Trapezoidal ramp
      base = n_rise;
      send(10, 1'b0, 1000, 400, 200);
      wait_done("t3", 12000);
      chk("t3_pulses", longint'(n_rise - base), 10);
      for (int k = 0; k < 9; k++)
         chk($sformatf("t3_per%0d", k), longint'(rise_t[base+k+1] - rise_t[base+k]), longint'(exp_p[k]));
      chk("t3_per9", longint'(done_t - rise_t[base+9]), longint'(exp_p[9]));
      chk("t3_hi0", longint'(fall_t[base] - rise_t[base]), 50);
      chk("t3_position", longint'(position), -7);
      chk("t3_steps_done", longint'(steps_done), 10);

      // Period clamp to 2*PULSE_HI
      base = n_rise;
      send(2, 1'b0, 30, 30, 0);
      wait_done("t4", 1000);
      chk("t4_pulses", longint'(n_rise - base), 2);
      chk("t4_hi", longint'(fall_t[base] - rise_t[base]), 50);
      chk("t4_per", longint'(rise_t[base+1] - rise_t[base]), 100);
      chk("t4_last_per", longint'(done_t - rise_t[base+1]), 100);
      chk("t4_position", longint'(position), -9);

      // Zero-step command: done the cycle after accept, no pulse, dir held
      base = n_rise;
      send(0, 1'b1, 200, 200, 0);
      chk("t4z_done", longint'(done), 1);
      chk("t4z_busy", longint'(busy), 0);
      chk("t4z_steps_done", longint'(steps_done), 0);
      @(negedge clk_50);
      chk("t4z_done_cleared", longint'(done), 0);
      repeat (20) @(negedge clk_50);
      chk("t4z_pulses", longint'(n_rise - base), 0);
      chk("t4z_dir", longint'(dir), 0);
      chk("t4z_position", longint'(position), -9);

      // Pause during step 2, resume after 500 cycles
      base = n_rise;
      send(6, 1'b0, 200, 200, 0);
      repeat (210) @(negedge clk_50);
      enable = 1'b0;
      repeat (250) @(negedge clk_50);
      chk("t5_pause_step", longint'(step), 0);
      chk("t5_pause_busy", longint'(busy), 1);
      chk("t5_pause_pulses", longint'(n_rise - base), 2);
      repeat (250) @(negedge clk_50);
      enable = 1'b1;
      wait_done("t5", 3000);
      chk("t5_first_rise", longint'(rise_t[base] - acc_cyc), 0);
      chk("t5_per0", longint'(rise_t[base+1] - rise_t[base]), 200);
      chk("t5_pause_gap", longint'(rise_t[base+2] - rise_t[base+1]), 511);
      chk("t5_per2", longint'(rise_t[base+3] - rise_t[base+2]), 200);
      chk("t5_pulses", longint'(n_rise - base), 6);
      chk("t5_steps_done", longint'(steps_done), 6);
      chk("t5_aborted", longint'(aborted), 0);
      chk("t5_position", longint'(position), -15);

      // Abort during HIGH of step 3 of 8; command while busy is ignored
      base = n_rise;
      send(8, 1'b1, 200, 200, 0);
      repeat (420) @(negedge clk_50);
      abort = 1'b1;
      repeat (5) @(negedge clk_50);
      cmd_if.cmd_steps = 16'd5;
      cmd_if.cmd_dir   = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      chk("t6_ready_busy", longint'(cmd_if.cmd_ready), 0);
      chk("t6_busy", longint'(busy), 1);
      @(negedge clk_50);
      cmd_if.cmd_valid = 1'b0;
      wait_done("t6", 2000);
      abort = 1'b0;
      chk("t6_aborted", longint'(aborted), 1);
      chk("t6_steps_done", longint'(steps_done), 3);
      chk("t6_pulses", longint'(n_rise - base), 3);
      chk("t6_setup", longint'(rise_t[base] - acc_cyc), 10);
      chk("t6_full_low", longint'(done_t - rise_t[base+2]), 200);
      chk("t6_position", longint'(position), -12);
      repeat (3) @(negedge clk_50);
      chk("t6_aborted_sticky", longint'(aborted), 1);
      send(0, 1'b1, 200, 200, 0);
      chk("t6_aborted_cleared", longint'(aborted), 0);
      chk("t6_steps_done_cleared", longint'(steps_done), 0);

      // Asynchronous reset in the middle of a pulse
      send(5, 1'b1, 200, 200, 0);
      repeat (20) @(negedge clk_50);
      chk("t7_step_before_reset", longint'(step), 1);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t7_step_async", longint'(step), 0);
      chk("t7_position_async", longint'(position), 0);
      chk("t7_busy_async", longint'(busy), 0);
      chk("t7_steps_done_async", longint'(steps_done), 0);
      @(negedge clk_50);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_50);
      chk("t7_ready_after", longint'(cmd_if.cmd_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stepper_ramp_driver.md
Name: stepper_ramp_driver

Overview:
Parametrised next-generation step/dir pulse generator for the SCARA joint drivers, running on clk_50.
- Accepts move commands (step count, direction, start/min period, ramp rate) over a valid/ready handshake.
- Emits STEP/DIR with a trapezoidal accel/decel profile, honouring driver timing: 1 us min high, 1 us min low, 200 ns dir setup.
- Tracks signed absolute position and supports pause (enable) and abort.
- Sits between the joint trajectory sequencer and the external driver pins.

Parameters:
STEP_W, 16, width of commanded step count and steps_done
PER_W, 24, width of period fields in clk_50 cycles
POS_W, 32, width of signed position accumulator
PULSE_HI, 50, STEP high time in cycles (1 us)
DIR_SETUP, 10, cycles from dir change to first rising STEP (200 ns)

Ports:
clk_50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high in IDLE only
cmd_steps  in  STEP_W  steps to issue
cmd_dir  in  1  direction (1 = positive)
cmd_per_start  in  PER_W  first/last step period, cycles
cmd_per_min  in  PER_W  cruise period, cycles
cmd_accel  in  PER_W  period change per step during ramps
enable  in  1  0 = pause at next step boundary
abort  in  1  level; stop at next step boundary
step  out  1  STEP pin
dir  out  1  DIR pin
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse on move end
aborted  out  1  sticky; valid with done, cleared on next accept
steps_done  out  STEP_W  rising edges issued in current/last move
position  out  POS_W  signed absolute position

Behaviour:
- Reset values: step=0, dir=0, done=0, aborted=0, busy=0, steps_done=0, position=0, state=IDLE, cmd_ready=1.
- Accept: cmd_valid & cmd_ready on a clock edge latches all cmd_* fields and clears steps_done and aborted.
- Period clamp at latch:
  - per_min = max(cmd_per_min, 2*PULSE_HI).
  - per_start = max(cmd_per_start, per_min).
  - cur_per = per_start.
- States: IDLE, SETUP, HIGH, LOW, PAUSE.
- IDLE, accept with cmd_steps==0: done pulses the next cycle, no STEP, stays IDLE.
- IDLE, accept otherwise:
  - dir_changed = (cmd_dir != dir); dir updates.
  - dir_changed: go to SETUP and wait DIR_SETUP cycles, then HIGH.
  - no direction change: go directly to HIGH the next cycle.
- HIGH:
  - step=1 for exactly PULSE_HI cycles.
  - On entry: steps_done+1; position +1 if dir=1, else -1 (wraps modulo 2^POS_W).
  - Then go to LOW.
- LOW:
  - step=0 for cur_per-PULSE_HI cycles.
  - At the end (step boundary), the next period is computed:
    - remaining = cmd_steps - steps_done.
    - remaining <= ramp_cnt (decel): cur_per = min(cur_per+cmd_accel, per_start); ramp_cnt-1.
    - else if cur_per > per_min (accel): cur_per = max(cur_per-cmd_accel, per_min); ramp_cnt+1.
    - else cruise, no change.
  - Arithmetic uses PER_W+1 bits; no wrap.
- Step-boundary priority at end of LOW:
  1. remaining==0 -> IDLE, done pulse.
  2. abort -> IDLE, done pulse, aborted=1.
  3. !enable -> PAUSE.
  4. else -> HIGH.
- PAUSE: step=0. Exits to HIGH the cycle after enable=1, or to IDLE with done and aborted on abort.
- enable and abort do not truncate a HIGH or LOW phase. Minimum pulse and low widths are always met.
- cmd_valid while busy is ignored: cmd_ready=0 and nothing is latched.
- Async reset mid-move: step drops to 0 immediately and position clears.
- dir changes only in IDLE.

Decomposition:
- Package stepper_pkg: state enum typedef (IDLE, SETUP, HIGH, LOW, PAUSE), default timing constants PULSE_HI_50M=50 and DIR_SETUP_50M=10.
- Sub-module step_ramp_calc: combinational next-period/ramp_cnt calculation, reusable across joints.
- Phase timer is a down-counter in the top module.

Test Plan:
- Reset, then accept steps=4, dir=1, per_start=per_min=200, accel=0 -> 4 pulses each 50 high / 150 low, period 200; done at end; position=4; steps_done=4.
- From dir=1, accept dir=0, steps=1 -> first STEP rise exactly 10 cycles after dir falls; position decrements by 1.
- Accept steps=10, per_start=1000, per_min=400, accel=200 -> periods 1000, 800, 600, 400, 400, 400, 400, 600, 800, 1000.
- Accept per_min=30 -> clamped to 100 (50 high / 50 low); steps=0 -> done one cycle after accept, no pulse.
- Drop enable mid-move for 500 cycles, then raise it -> current pulse completes, STEP held low in PAUSE, move resumes, total pulses unchanged.
- Assert abort during HIGH of step 3 of 8 -> pulse completes, full LOW completes, then done with aborted=1, steps_done=3; cmd_valid during busy is not accepted.
